time_of_day_counter: RTL

- Consumes the slow square-wave tick from the clock divider stage.
- Advances a time-of-day count (hours, minutes, seconds) by one second on every rising edge of that tick.
- Supports a set mode for manual adjustment of minutes and hours.
- Drives BCD time digits and one-cycle event pulses to the downstream display/alarm logic.

---
 rtl/time_of_day_counter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/time_of_day_counter.sv
// Time-of-day counter. Each rising edge of the divided tick advances HH:MM:SS by one second.
// A set mode lets the user bump minutes and hours. Outputs are BCD digits plus one-cycle event pulses.
module time_of_day_counter #(
  parameter bit          HOURS_24   = 1'b1,
  parameter int unsigned RESET_HOUR = 0,
  parameter int unsigned RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tick_in,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam logic [7:0] RST_MIN_BCD = {4'(RESET_MIN / 10), 4'(RESET_MIN % 10)};
  localparam logic [4:0] RST_HOUR    = 5'(RESET_HOUR);

  logic       tick_q, inc_min_q, inc_hour_q, set_mode_q;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       day_pulse_q, day_pulse_d;

  logic tick_rise, min_rise, hour_rise, set_rise;
  logic advance, sec_wrap, min_wrap, hour_wrap;
  logic [4:0] disp_hour;

  // Increment a 00..59 BCD pair, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] hour_to_bcd(input logic [4:0] v);
    logic [4:0] ones;
    logic [3:0] tens;
    if (v >= 5'd20) begin
      tens = 4'd2;
      ones = v - 5'd20;
    end else if (v >= 5'd10) begin
      tens = 4'd1;
      ones = v - 5'd10;
    end else begin
      tens = 4'd0;
      ones = v;
    end
    return {tens, ones[3:0]};
  endfunction

  assign tick_rise = tick_in  & ~tick_q;
  assign min_rise  = inc_min  & ~inc_min_q;
  assign hour_rise = inc_hour & ~inc_hour_q;
  assign set_rise  = set_mode & ~set_mode_q;

  assign advance   = enable & ~set_mode & tick_rise;
  assign sec_wrap  = (sec_q == 8'h59);
  assign min_wrap  = (min_q == 8'h59);
  assign hour_wrap = (hour_q == 5'd23);

  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sec_pulse_d = advance;
    day_pulse_d = advance & sec_wrap & min_wrap & hour_wrap;
    if (advance) begin
      sec_d = bcd_inc60(sec_q);
      if (sec_wrap) begin
        min_d = bcd_inc60(min_q);
        if (min_wrap) begin
          hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
        end
      end
    end else if (enable && set_mode) begin
      // Manual adjustments never carry between fields.
      if (set_rise) begin
        sec_d = 8'h00;
      end
      if (min_rise) begin
        min_d = bcd_inc60(min_q);
      end
      if (hour_rise) begin
        hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
      end
    end
  end

  // Edge history tracks inputs even while frozen, so re-enabling with a high tick is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      set_mode_q <= 1'b0;
    end else begin
      tick_q     <= tick_in;
      inc_min_q  <= inc_min;
      inc_hour_q <= inc_hour;
      set_mode_q <= set_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= 8'h00;
      min_q       <= RST_MIN_BCD;
      hour_q      <= RST_HOUR;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  always_comb begin
    disp_hour = hour_q;
    if (!HOURS_24) begin
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  assign sec_bcd   = sec_q;
  assign min_bcd   = min_q;
  assign hour_bcd  = hour_to_bcd(disp_hour);
  assign pm        = (hour_q >= 5'd12);
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

  always @(posedge clk) begin
    assert (RESET_HOUR <= 23 && RESET_MIN <= 59)
      else $error("time_of_day_counter: RESET_HOUR/RESET_MIN out of range");
  end

endmodule
